// File: rtl/mdr_mem_pkg.sv
// mdr_mem_pkg: shared types and constants for the MDR / memory sequencer.
//   mdr_state_e    : transaction sequencer states
//   DATA_WIDTH_DEF : default MDR / bus / memory data width
//   ADDR_WIDTH_DEF : default memory word address width
//   is_wait()      : true in the states that hold a memory request open
package mdr_mem_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERR     = 3'd4
  } mdr_state_e;

  function automatic logic is_wait(input mdr_state_e s);
    return (s == ST_RD_WAIT) || (s == ST_WR_WAIT);
  endfunction

endpackage

// File: rtl/mdr_mem_fsm.sv
// mdr_mem_fsm: memory transaction sequencer (state register, handshake
// outputs, optional timeout counter).
//   clock, clear_n       : clock, async active-low reset
//   i_rd_start/i_wr_start: start pulses (honoured in IDLE, read wins)
//   i_mem_ack            : memory completion strobe
//   o_idle               : sequencer is in IDLE (MDR bus load / addr capture)
//   o_rd_cap             : load MDR from memory read data this edge
//   o_mem_req/o_mem_we   : handshake outputs, decoded from state
//   o_busy/o_done/o_error: status to control unit, decoded from state
// Build option: define MDR_TIMEOUT_EN to abort waits after TIMEOUT_CYCLES.
module mdr_mem_fsm
  import mdr_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic clear_n,
  input  logic i_rd_start,
  input  logic i_wr_start,
  input  logic i_mem_ack,
  output logic o_idle,
  output logic o_rd_cap,
  output logic o_mem_req,
  output logic o_mem_we,
  output logic o_busy,
  output logic o_done,
  output logic o_error
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mdr_mem_fsm: TIMEOUT_CYCLES must be 1..255");
  end

  mdr_state_e r_state, w_next;
  logic       w_timeout;

`ifdef MDR_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_cnt;

  // Held at zero in IDLE so every wait state starts from a clean count;
  // r_cnt == TO_LAST means this is the last permitted wait cycle.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)                             r_cnt <= '0;
    else if (r_state == ST_IDLE)              r_cnt <= '0;
    else if (is_wait(r_state) && !i_mem_ack)  r_cnt <= r_cnt + 8'd1;
  end

  assign w_timeout = (r_cnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_rd_start)      w_next = ST_RD_WAIT;
        else if (i_wr_start) w_next = ST_WR_WAIT;
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        // ack on the terminal-count edge still completes normally
        if (i_mem_ack)      w_next = ST_DONE;
        else if (w_timeout) w_next = ST_ERR;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  assign o_idle    = (r_state == ST_IDLE);
  assign o_rd_cap  = (r_state == ST_RD_WAIT) && i_mem_ack;
  assign o_mem_req = is_wait(r_state);
  assign o_mem_we  = (r_state == ST_WR_WAIT);
  assign o_busy    = is_wait(r_state);
  assign o_done    = (r_state == ST_DONE);
`ifdef MDR_TIMEOUT_EN
  assign o_error   = (r_state == ST_ERR);
`else
  assign o_error   = 1'b0;
`endif

endmodule

// File: rtl/mdr_mem_unit.sv
// mdr_mem_unit: Memory Data Register plus memory-transaction sequencer.
//   BusMuxOut/MDRin         : bus load path (IDLE only)
//   addr_in                 : MAR value, captured at transaction start
//   rd_start/wr_start       : start pulses
//   mem_rdata/mem_ack       : memory response
//   mem_req/mem_we/mem_addr/mem_wdata : memory request side
//   BusMuxIn_MDR            : MDR value to bus mux
//   busy/done/error         : status to control unit
// Build option: MDR_TIMEOUT_EN enables the wait-state timeout abort.
module mdr_mem_unit
  import mdr_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic [DATA_WIDTH-1:0] BusMuxOut,
  input  logic                  MDRin,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  rd_start,
  input  logic                  wr_start,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] BusMuxIn_MDR,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  logic [DATA_WIDTH-1:0] r_mdr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  w_idle, w_rd_cap;

  mdr_mem_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_fsm (
    .clock      (clock),
    .clear_n    (clear_n),
    .i_rd_start (rd_start),
    .i_wr_start (wr_start),
    .i_mem_ack  (mem_ack),
    .o_idle     (w_idle),
    .o_rd_cap   (w_rd_cap),
    .o_mem_req  (mem_req),
    .o_mem_we   (mem_we),
    .o_busy     (busy),
    .o_done     (done),
    .o_error    (error)
  );

  // Bus load and memory capture never coincide (IDLE vs RD_WAIT); a bus
  // load alongside rd_start is simply overwritten when the read returns.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)            r_mdr <= '0;
    else if (w_rd_cap)       r_mdr <= mem_rdata;
    else if (w_idle && MDRin) r_mdr <= BusMuxOut;
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)                              r_addr <= '0;
    else if (w_idle && (rd_start || wr_start)) r_addr <= addr_in;
  end

  assign mem_addr     = r_addr;
  assign mem_wdata    = r_mdr;
  assign BusMuxIn_MDR = r_mdr;

endmodule

// File: tb/tb_mdr_mem_unit.sv
module tb_mdr_mem_unit;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int TO = 4;

  localparam int M_IDLE = 0, M_RD = 1, M_WR = 2, M_DONE = 3, M_ERR = 4;

  logic          clock = 1'b0, clear_n = 1'b0;
  logic [DW-1:0] BusMuxOut = '0, mem_rdata = '0;
  logic          MDRin = 1'b0, rd_start = 1'b0, wr_start = 1'b0, mem_ack = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic          mem_req, mem_we, busy, done, error;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, BusMuxIn_MDR;

  mdr_mem_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .clear_n(clear_n), .BusMuxOut(BusMuxOut), .MDRin(MDRin),
    .addr_in(addr_in), .rd_start(rd_start), .wr_start(wr_start),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .BusMuxIn_MDR(BusMuxIn_MDR), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: phase, stored word, captured address,
  // and the number of wait cycles spent on the current transaction.
  int          m_st;
  logic [DW-1:0] m_mdr;
  logic [AW-1:0] m_addr;
  int          m_wait;

  task automatic model_reset();
    m_st = M_IDLE; m_mdr = '0; m_addr = '0; m_wait = 0;
  endtask

  task automatic model_step();
    case (m_st)
      M_IDLE: begin
        if (MDRin) m_mdr = BusMuxOut;
        if (rd_start)      begin m_addr = addr_in; m_st = M_RD; m_wait = 0; end
        else if (wr_start) begin m_addr = addr_in; m_st = M_WR; m_wait = 0; end
      end
      M_RD, M_WR: begin
        if (mem_ack) begin
          if (m_st == M_RD) m_mdr = mem_rdata;
          m_st = M_DONE;
        end else begin
          m_wait = m_wait + 1;
`ifdef MDR_TIMEOUT_EN
          if (m_wait == TO) m_st = M_ERR;
`endif
        end
      end
      default: m_st = M_IDLE;
    endcase
  endtask

  task automatic check_all();
    chk("mem_req",  mem_req,  (m_st == M_RD) || (m_st == M_WR));
    chk("busy",     busy,     (m_st == M_RD) || (m_st == M_WR));
    chk("mem_we",   mem_we,   m_st == M_WR);
    chk("done",     done,     m_st == M_DONE);
    chk("error",    error,    m_st == M_ERR);
    chk("mem_addr", mem_addr, m_addr);
    chk("mdr",      BusMuxIn_MDR, m_mdr);
    chk("wdata",    mem_wdata, m_mdr);
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  int reqs;

  initial begin
    model_reset();
    #3;
    check_all();
    chk("rst_all", {mem_req, mem_we, busy, done, error}, 5'b0);
    @(posedge clock); #1;
    clear_n = 1'b1;

    // bus load
    BusMuxOut = 32'hDEADBEEF; MDRin = 1'b1;
    cyc();
    MDRin = 1'b0;
    chk("load", BusMuxIn_MDR, 32'hDEADBEEF);

    // read with 3 wait cycles
    addr_in = 9'h0A5; rd_start = 1'b1;
    cyc();
    rd_start = 1'b0; reqs = 0;
    chk("rd_addr", mem_addr, 9'h0A5);
    chk("rd_we", mem_we, 1'b0);
    if (mem_req) reqs++;
    cyc(); if (mem_req) reqs++;
    cyc(); if (mem_req) reqs++;
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    cyc(); if (mem_req) reqs++;
    mem_ack = 1'b0;
    chk("rd_reqcnt", reqs, 3);
    chk("rd_done", done, 1'b1);
    cyc();
    chk("rd_done_once", done, 1'b0);
    chk("rd_mdr", BusMuxIn_MDR, 32'h12345678);

    // write with same-cycle load
    BusMuxOut = 32'hCAFEF00D; MDRin = 1'b1; wr_start = 1'b1; addr_in = 9'h100;
    cyc();
    MDRin = 1'b0; wr_start = 1'b0;
    chk("wr_we", mem_we, 1'b1);
    chk("wr_wdata", mem_wdata, 32'hCAFEF00D);
    mem_ack = 1'b1; mem_rdata = 32'h0;
    cyc();
    mem_ack = 1'b0;
    chk("wr_done", done, 1'b1);
    chk("wr_mdr", BusMuxIn_MDR, 32'hCAFEF00D);
    cyc();

    // rd+wr together: read wins; bus load ignored while waiting
    rd_start = 1'b1; wr_start = 1'b1; addr_in = 9'h011;
    cyc();
    rd_start = 1'b0; wr_start = 1'b0;
    chk("prio_we", mem_we, 1'b0);
    chk("prio_req", mem_req, 1'b1);
    MDRin = 1'b1; BusMuxOut = 32'h1;
    cyc();
    MDRin = 1'b0;
    chk("busload_ign", BusMuxIn_MDR, 32'hCAFEF00D);
    mem_ack = 1'b1; mem_rdata = 32'h55AA33CC;
    cyc();
    mem_ack = 1'b0;
    cyc();
    chk("prio_mdr", BusMuxIn_MDR, 32'h55AA33CC);

    // stray ack in IDLE
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    cyc();
    mem_ack = 1'b0;
    chk("stray_ack", {busy, done, error}, 3'b0);
    chk("stray_mdr", BusMuxIn_MDR, 32'h55AA33CC);

    // reset mid-read
    addr_in = 9'h033; rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    cyc();
    clear_n = 1'b0;
    #1;
    model_reset();
    chk("rstmid_req", mem_req, 1'b0);
    chk("rstmid_mdr", BusMuxIn_MDR, 32'h0);
    check_all();
    #2;
    clear_n = 1'b1;
    addr_in = 9'h1FF; rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    chk("rerd_addr", mem_addr, 9'h1FF);
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    cyc();
    mem_ack = 1'b0;
    chk("rerd_done", done, 1'b1);
    cyc();
    chk("rerd_mdr", BusMuxIn_MDR, 32'h0BADF00D);

`ifdef MDR_TIMEOUT_EN
    // read never acked: error after TO wait cycles, MDR kept
    rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    for (int i = 0; i < TO - 1; i++) cyc();
    chk("to_still_wait", mem_req, 1'b1);
    cyc();
    chk("to_error", error, 1'b1);
    chk("to_mdr", BusMuxIn_MDR, 32'h0BADF00D);
    cyc();
    chk("to_idle", {mem_req, error}, 2'b0);
    // ack on the terminal cycle wins
    rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    for (int i = 0; i < TO - 1; i++) cyc();
    mem_ack = 1'b1; mem_rdata = 32'h00C0FFEE;
    cyc();
    mem_ack = 1'b0;
    chk("to_ack_done", {done, error}, 2'b10);
    cyc();
    chk("to_ack_mdr", BusMuxIn_MDR, 32'h00C0FFEE);
`endif

    // randomized traffic, including occasional async resets
    for (int n = 0; n < 3000; n++) begin
      rd_start  = ($urandom_range(0, 7) == 0);
      wr_start  = ($urandom_range(0, 7) == 0);
      MDRin     = ($urandom_range(0, 3) == 0);
      BusMuxOut = $urandom;
      addr_in   = AW'($urandom);
      mem_ack   = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        clear_n = 1'b0;
        #1;
        model_reset();
        check_all();
        clear_n = 1'b1;
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
